morse_tx: RTL

//  Morse transmitter: the sending-side counterpart of morse_rx. Accepts 6-bit character

---
 rtl/morse_tx.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/morse_tx.sv
`default_nettype none
// ============================================================================
// Module      : morse_tx
// Description : Morse code transmitter. Accepts 6-bit character codes over a
//               valid/ready handshake and keys them onto a single on/off
//               output with standard Morse timing (dot = 1 unit, dash = 3,
//               inter-symbol space = 1, character gap and word gap set by
//               parameters). Contains its own unit-time counter.
//               Code map: 0-25 = A-Z, 26-35 = 0-9, 36 = word space,
//               37-63 = invalid (flagged on code_err).
// Ports       : clk_100MHz  in   system clock, rising edge
//               reset       in   asynchronous, active-low reset
//               char_data   in   [5:0] character code
//               char_valid  in   source has a character
//               char_ready  out  block can accept a character
//               tx_out      out  keyed output, 1 = mark
//               busy        out  character or gap in progress
//               code_err    out  one-cycle pulse on accepted invalid code
// Revision    : 1.0 - initial release
// ============================================================================
module morse_tx #(
  parameter int UNIT_CYCLES    = 6_000_000,
  parameter int CHAR_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS = 4
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [5:0] char_data,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       code_err
);

  localparam int              CNT_W         = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [2:0]       CHAR_GAP_LAST = 3'(CHAR_GAP_UNITS - 1);
  localparam logic [2:0]       WORD_GAP_LAST = 3'(WORD_GAP_UNITS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MARK     = 3'd1,
    S_SPACE    = 3'd2,
    S_CHAR_GAP = 3'd3,
    S_WORD_GAP = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] unit_cnt, unit_cnt_nx;
  logic [2:0]       units, units_nx;
  logic [2:0]       sym_idx, sym_idx_nx;
  logic [4:0]       pat, pat_nx;
  logic             err_nx;

  logic [7:0]       rom_entry;
  logic [2:0]       rom_len;
  logic [4:0]       rom_pat;
  logic             accept;
  logic             unit_done;
  logic [2:0]       units_last;
  logic             phase_end;

  // Character ROM: {len, pat}; symbols sent MSB-first from pat[len-1:0],
  // 1 = dash, 0 = dot.
  always_comb begin
    rom_entry = 8'h00;
    case (char_data)
      6'd0:  rom_entry = {3'd2, 5'b00001}; // A .-
      6'd1:  rom_entry = {3'd4, 5'b01000}; // B -...
      6'd2:  rom_entry = {3'd4, 5'b01010}; // C -.-.
      6'd3:  rom_entry = {3'd3, 5'b00100}; // D -..
      6'd4:  rom_entry = {3'd1, 5'b00000}; // E .
      6'd5:  rom_entry = {3'd4, 5'b00010}; // F ..-.
      6'd6:  rom_entry = {3'd3, 5'b00110}; // G --.
      6'd7:  rom_entry = {3'd4, 5'b00000}; // H ....
      6'd8:  rom_entry = {3'd2, 5'b00000}; // I ..
      6'd9:  rom_entry = {3'd4, 5'b00111}; // J .---
      6'd10: rom_entry = {3'd3, 5'b00101}; // K -.-
      6'd11: rom_entry = {3'd4, 5'b00100}; // L .-..
      6'd12: rom_entry = {3'd2, 5'b00011}; // M --
      6'd13: rom_entry = {3'd2, 5'b00010}; // N -.
      6'd14: rom_entry = {3'd3, 5'b00111}; // O ---
      6'd15: rom_entry = {3'd4, 5'b00110}; // P .--.
      6'd16: rom_entry = {3'd4, 5'b01101}; // Q --.-
      6'd17: rom_entry = {3'd3, 5'b00010}; // R .-.
      6'd18: rom_entry = {3'd3, 5'b00000}; // S ...
      6'd19: rom_entry = {3'd1, 5'b00001}; // T -
      6'd20: rom_entry = {3'd3, 5'b00001}; // U ..-
      6'd21: rom_entry = {3'd4, 5'b00001}; // V ...-
      6'd22: rom_entry = {3'd3, 5'b00011}; // W .--
      6'd23: rom_entry = {3'd4, 5'b01001}; // X -..-
      6'd24: rom_entry = {3'd4, 5'b01011}; // Y -.--
      6'd25: rom_entry = {3'd4, 5'b01100}; // Z --..
      6'd26: rom_entry = {3'd5, 5'b11111}; // 0
      6'd27: rom_entry = {3'd5, 5'b01111}; // 1
      6'd28: rom_entry = {3'd5, 5'b00111}; // 2
      6'd29: rom_entry = {3'd5, 5'b00011}; // 3
      6'd30: rom_entry = {3'd5, 5'b00001}; // 4
      6'd31: rom_entry = {3'd5, 5'b00000}; // 5
      6'd32: rom_entry = {3'd5, 5'b10000}; // 6
      6'd33: rom_entry = {3'd5, 5'b11000}; // 7
      6'd34: rom_entry = {3'd5, 5'b11100}; // 8
      6'd35: rom_entry = {3'd5, 5'b11110}; // 9
      default: rom_entry = 8'h00;
    endcase
  end

  assign rom_len = rom_entry[7:5];
  assign rom_pat = rom_entry[4:0];

  // char_ready is high exactly in IDLE, so it doubles as the accept qualifier.
  assign accept    = char_valid & char_ready;
  assign unit_done = (unit_cnt == CNT_LAST);

  // Index of the last unit of the current phase.
  always_comb begin
    units_last = 3'd0;
    case (state)
      S_MARK:     units_last = pat[sym_idx] ? 3'd2 : 3'd0;
      S_SPACE:    units_last = 3'd0;
      S_CHAR_GAP: units_last = CHAR_GAP_LAST;
      S_WORD_GAP: units_last = WORD_GAP_LAST;
      default:    units_last = 3'd0;
    endcase
  end

  assign phase_end = unit_done && (units == units_last);

  // Next-state and datapath logic.
  always_comb begin
    state_nx    = state;
    unit_cnt_nx = unit_done ? '0 : unit_cnt + 1'b1;
    units_nx    = units;
    sym_idx_nx  = sym_idx;
    pat_nx      = pat;
    err_nx      = 1'b0;

    if (phase_end) begin
      units_nx = 3'd0;
    end else if (unit_done) begin
      units_nx = units + 3'd1;
    end

    case (state)
      S_IDLE: begin
        // Every phase starts with fresh counters.
        unit_cnt_nx = '0;
        units_nx    = 3'd0;
        if (accept) begin
          if (char_data <= 6'd35) begin
            pat_nx     = rom_pat;
            sym_idx_nx = rom_len - 3'd1;
            state_nx   = S_MARK;
          end else if (char_data == 6'd36) begin
            state_nx = S_WORD_GAP;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      S_MARK: begin
        if (phase_end) begin
          if (sym_idx == 3'd0) begin
            state_nx = S_CHAR_GAP;
          end else begin
            state_nx   = S_SPACE;
            sym_idx_nx = sym_idx - 3'd1;
          end
        end
      end
      S_SPACE: begin
        if (phase_end) state_nx = S_MARK;
      end
      S_CHAR_GAP, S_WORD_GAP: begin
        if (phase_end) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // All outputs are registered from the next-state value so they change
  // on the same edge as the state itself.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      unit_cnt   <= '0;
      units      <= 3'd0;
      sym_idx    <= 3'd0;
      pat        <= 5'd0;
      char_ready <= 1'b1;
      tx_out     <= 1'b0;
      busy       <= 1'b0;
      code_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      unit_cnt   <= unit_cnt_nx;
      units      <= units_nx;
      sym_idx    <= sym_idx_nx;
      pat        <= pat_nx;
      char_ready <= (state_nx == S_IDLE);
      tx_out     <= (state_nx == S_MARK);
      busy       <= (state_nx != S_IDLE);
      code_err   <= err_nx;
    end
  end

endmodule
`default_nettype wire
